gb_timer_ctrl: RTL and testbench

Game Boy timer/divider controller. Sequences a 16-bit free-running divider and the TIMA event counter from a T-cycle enable, selects the TIMA increment rate from TAC, handles overflow reload from TMA with the hardware reload delay, and raises the timer interrupt. Sits on the CPU I/O bus at FF04–FF07 and drives the timer bit of the interrupt controller.

---
 rtl/gb_timer_ctrl_if.sv | 20 ++
 rtl/gb_timer_ctrl.sv | 131 +++++++++++++
 tb/tb_gb_timer_ctrl.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/gb_timer_ctrl_if.sv
// CPU I/O bus view of the timer block at FF04-FF07, plus the timer interrupt request.
interface gb_timer_ctrl_if;
  logic [1:0] addr_in;
  logic       wr_in;
  logic       rd_in;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       rd_valid_out;
  logic       irq_out;

  modport master (
    output addr_in, wr_in, rd_in, data_in,
    input  data_out, rd_valid_out, irq_out
  );

  modport slave (
    input  addr_in, wr_in, rd_in, data_in,
    output data_out, rd_valid_out, irq_out
  );
endinterface

// File: rtl/gb_timer_ctrl.sv
// Game Boy DIV/TIMA/TMA/TAC timer: free-running divider, tap-selected TIMA counting,
// delayed TMA reload on overflow and a one-clk timer interrupt pulse.
module gb_timer_ctrl #(
  parameter int unsigned OVF_DELAY = 4
) (
  input  logic           clk_in,
  input  logic           rst_in,
  input  logic           t_tick_in,
  gb_timer_ctrl_if.slave bus
);

  localparam int unsigned DIV_W = 16;
  localparam int unsigned REG_W = 8;
  localparam int unsigned TAC_W = 3;
  localparam int unsigned DLY_W = 4;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    OVF    = 2'd1,
    RELOAD = 2'd2
  } state_t;

  state_t             state;
  logic [DIV_W-1:0]   div;
  logic [REG_W-1:0]   tima;
  logic [REG_W-1:0]   tma;
  logic [TAC_W-1:0]   tac;
  logic [DLY_W-1:0]   dly_cnt;
  logic               sel_q;

  logic               tap_c;
  logic               sel_c;
  logic               fall_c;
  logic               wr_div_c;
  logic               wr_tima_c;
  logic               wr_tma_c;
  logic               wr_tac_c;
  logic [REG_W-1:0]   rd_mux_c;

  // Increment source: selected divider tap gated by the enable, edge-detected against last clk.
  always_comb begin
    tap_c = 1'b0;
    case (tac[1:0])
      2'b00: tap_c = div[9];
      2'b01: tap_c = div[3];
      2'b10: tap_c = div[5];
      2'b11: tap_c = div[7];
      default: tap_c = 1'b0;
    endcase
    sel_c  = tap_c & tac[2];
    fall_c = sel_q & ~sel_c;
  end

  always_comb begin
    wr_div_c  = bus.wr_in && (bus.addr_in == 2'd0);
    wr_tima_c = bus.wr_in && (bus.addr_in == 2'd1);
    wr_tma_c  = bus.wr_in && (bus.addr_in == 2'd2);
    wr_tac_c  = bus.wr_in && (bus.addr_in == 2'd3);
    rd_mux_c  = '0;
    case (bus.addr_in)
      2'd0: rd_mux_c = div[15:8];
      2'd1: rd_mux_c = tima;
      2'd2: rd_mux_c = tma;
      2'd3: rd_mux_c = {5'b11111, tac};
      default: rd_mux_c = '0;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state            <= RUN;
      div              <= '0;
      tima             <= '0;
      tma              <= '0;
      tac              <= '0;
      dly_cnt          <= '0;
      sel_q            <= 1'b0;
      bus.irq_out      <= 1'b0;
      bus.data_out     <= '0;
      bus.rd_valid_out <= 1'b0;
    end else begin
      bus.irq_out      <= 1'b0;
      bus.rd_valid_out <= bus.rd_in;
      sel_q            <= sel_c;
      if (bus.rd_in) bus.data_out <= rd_mux_c;

      if (wr_div_c)       div <= '0;
      else if (t_tick_in) div <= div + DIV_W'(1);

      if (wr_tma_c) tma <= bus.data_in;
      if (wr_tac_c) tac <= bus.data_in[TAC_W-1:0];

      case (state)
        RUN: begin
          if (wr_tima_c) begin
            tima <= bus.data_in;
          end else if (fall_c) begin
            if (tima == 8'hFF) begin
              tima    <= '0;
              dly_cnt <= DLY_W'(OVF_DELAY - 1);
              state   <= OVF;
            end else begin
              tima <= tima + REG_W'(1);
            end
          end
        end
        // Overflow window: edges ignored, a TIMA write aborts the pending reload.
        OVF: begin
          if (wr_tima_c) begin
            tima  <= bus.data_in;
            state <= RUN;
          end else if (t_tick_in) begin
            if (dly_cnt == '0) begin
              state       <= RELOAD;
              bus.irq_out <= 1'b1;
            end else begin
              dly_cnt <= dly_cnt - DLY_W'(1);
            end
          end
        end
        // A TMA write landing in the reload cycle feeds straight through to TIMA.
        RELOAD: begin
          tima  <= wr_tma_c ? bus.data_in : tma;
          state <= RUN;
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_gb_timer_ctrl.sv
// Directed bench for gb_timer_ctrl: reset, divider, rates, overflow/reload, cancel and glitch cases.
module tb_gb_timer_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tick = 1'b0;
  int   tests = 0;
  int   fails = 0;
  int   irq_cnt = 0;
  int   irq_base;

  gb_timer_ctrl_if bus ();

  gb_timer_ctrl #(.OVF_DELAY(4)) dut (
    .clk_in    (clk),
    .rst_in    (rst),
    .t_tick_in (tick),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (bus.irq_out) irq_cnt++;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic ticks(input int n);
    tick = 1'b1;
    for (int i = 0; i < n; i++) step();
    tick = 1'b0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    bus.addr_in = a;
    bus.data_in = d;
    bus.wr_in   = 1'b1;
    step();
    bus.wr_in   = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [1:0] a, input logic [7:0] exp);
    bus.addr_in = a;
    bus.rd_in   = 1'b1;
    step();
    bus.rd_in   = 1'b0;
    check(tag, 32'(bus.data_out), 32'(exp));
  endtask

  // Leaves the DUT in OVF on the clk after the TIMA 0xFF->0x00 increment; div ends at 16.
  task automatic to_ovf();
    wr(2'd3, 8'h00);
    wr(2'd0, 8'h00);
    wr(2'd2, 8'hF0);
    wr(2'd1, 8'hFF);
    wr(2'd3, 8'h05);
    ticks(16);
    step();
  endtask

  initial begin
    bus.addr_in = '0;
    bus.wr_in   = 1'b0;
    bus.rd_in   = 1'b0;
    bus.data_in = '0;
    step();
    step();
    rst = 1'b0;

    // Reset mid-count
    wr(2'd2, 8'h5C);
    wr(2'd3, 8'h05);
    ticks(700);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst_data_out", 32'(bus.data_out), 32'h00);
    check("rst_rd_valid", 32'(bus.rd_valid_out), 32'h0);
    check("rst_irq", 32'(bus.irq_out), 32'h0);
    rd_chk("rst_div", 2'd0, 8'h00);
    check("rd_valid", 32'(bus.rd_valid_out), 32'h1);
    rd_chk("rst_tima", 2'd1, 8'h00);
    rd_chk("rst_tma", 2'd2, 8'h00);
    rd_chk("rst_tac", 2'd3, 8'hF8);
    step();
    check("rd_valid_drop", 32'(bus.rd_valid_out), 32'h0);

    // Divider
    ticks(256);
    rd_chk("div_256", 2'd0, 8'h01);
    ticks(65536 - 256);
    rd_chk("div_wrap", 2'd0, 8'h00);
    ticks(16'h1234);
    rd_chk("div_1234", 2'd0, 8'h12);
    wr(2'd0, 8'h5A);
    rd_chk("div_clear", 2'd0, 8'h00);

    // Rates
    wr(2'd3, 8'h00);
    wr(2'd0, 8'h00);
    wr(2'd1, 8'h00);
    wr(2'd3, 8'h05);
    ticks(160);
    step();
    rd_chk("rate_16", 2'd1, 8'd10);
    wr(2'd3, 8'h00);
    wr(2'd0, 8'h00);
    wr(2'd1, 8'h00);
    wr(2'd3, 8'h04);
    ticks(2048);
    step();
    rd_chk("rate_1024", 2'd1, 8'd2);
    wr(2'd3, 8'h01);
    ticks(64);
    step();
    rd_chk("rate_disabled", 2'd1, 8'd2);

    // Overflow and reload
    irq_base = irq_cnt;
    to_ovf();
    rd_chk("ovf_tima0", 2'd1, 8'h00);
    ticks(3);
    check("ovf_no_irq_early", 32'(bus.irq_out), 32'h0);
    rd_chk("ovf_tima0_late", 2'd1, 8'h00);
    ticks(1);
    check("ovf_irq_pulse", 32'(bus.irq_out), 32'h1);
    step();
    check("ovf_irq_drop", 32'(bus.irq_out), 32'h0);
    rd_chk("ovf_reload", 2'd1, 8'hF0);
    check("ovf_irq_count", 32'(irq_cnt - irq_base), 32'd1);

    // Cancel by TIMA write during OVF
    irq_base = irq_cnt;
    to_ovf();
    ticks(1);
    wr(2'd1, 8'h33);
    ticks(6);
    step();
    rd_chk("cancel_tima", 2'd1, 8'h33);
    check("cancel_no_irq", 32'(irq_cnt - irq_base), 32'd0);

    // TMA write in the reload cycle
    irq_base = irq_cnt;
    to_ovf();
    ticks(4);
    check("override_irq_high", 32'(bus.irq_out), 32'h1);
    wr(2'd2, 8'h77);
    rd_chk("override_tima", 2'd1, 8'h77);
    check("override_irq_count", 32'(irq_cnt - irq_base), 32'd1);

    // Simultaneous read and write returns the pre-write value
    bus.addr_in = 2'd2;
    bus.data_in = 8'h99;
    bus.wr_in   = 1'b1;
    bus.rd_in   = 1'b1;
    step();
    bus.wr_in   = 1'b0;
    bus.rd_in   = 1'b0;
    check("rdwr_prewrite", 32'(bus.data_out), 32'h77);
    rd_chk("rdwr_after", 2'd2, 8'h99);

    // Edge glitches with div[3]=1
    wr(2'd3, 8'h00);
    wr(2'd0, 8'h00);
    wr(2'd1, 8'h10);
    wr(2'd3, 8'h05);
    ticks(8);
    step();
    wr(2'd0, 8'hAA);
    step();
    rd_chk("glitch_div_wr", 2'd1, 8'h11);
    wr(2'd3, 8'h00);
    wr(2'd0, 8'h00);
    wr(2'd1, 8'h20);
    wr(2'd3, 8'h05);
    ticks(8);
    step();
    wr(2'd3, 8'h01);
    step();
    rd_chk("glitch_tac_wr", 2'd1, 8'h21);

    // Same writes with div[3]=0
    wr(2'd3, 8'h00);
    wr(2'd0, 8'h00);
    wr(2'd1, 8'h30);
    wr(2'd3, 8'h05);
    ticks(4);
    step();
    wr(2'd0, 8'h00);
    step();
    rd_chk("noglitch_div_wr", 2'd1, 8'h30);
    wr(2'd1, 8'h40);
    ticks(4);
    step();
    wr(2'd3, 8'h01);
    step();
    rd_chk("noglitch_tac_wr", 2'd1, 8'h40);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
